id_ex_stage: RTL
================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameters: none; data width fixed at 32, register index width fixed at 5; alu_op_t taken from control_types_pkg.
REQ-002 One clock; reset is synchronous and active-high.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 stall_in  in  1  external hold; stage register keeps its contents.
REQ-006 flush  in  1  squash; bubble captured at next edge.
REQ-007 id_valid  in  1  ID holds a real instruction.
REQ-008 id_pc, id_imm, id_rs1_data, id_rs2_data  in  32 each  decoded PC, immediate, register-file read data.
REQ-009 id_rs1_addr, id_rs2_addr, id_rd_addr  in  5 each  source/destination indices.
REQ-010 id_alu_op  in  alu_op_t  ALU operation.
REQ-011 id_a_sel, id_b_sel  in  1 each  A: 0=rs1, 1=PC; B: 0=rs2, 1=imm.
REQ-012 id_reg_write, id_mem_read  in  1 each  writes rd; is a load.
REQ-013 exmem_reg_write, memwb_reg_write  in  1 each; exmem_rd_addr, memwb_rd_addr  in  5 each; exmem_result, memwb_result  in  32 each  forwarding sources.
REQ-014 operand_a, operand_b  out  32 each  to ALU.
REQ-015 alu_op  out  alu_op_t  to ALU.
REQ-016 ex_valid, ex_reg_write, ex_mem_read  out  1 each; ex_rd_addr  out  5; ex_store_data  out  32 (forwarded rs2).
REQ-017 load_use_stall  out  1  request for upstream to hold PC/IF/ID.

Function
REQ-018 Stage register holds valid, pc, imm, rs1/rs2 data and addrs, rd, alu_op, a_sel, b_sel, reg_write, mem_read.
REQ-019 Edge update priority: rst > flush > stall_in (hold) > load_use_stall (bubble) > capture ID inputs.
REQ-020 Bubble: valid=0, alu_op=ALU_NOP, reg_write=0, mem_read=0, rd=0, rs1/rs2 addrs=0; data fields don't-care.
REQ-021 Capture with id_valid=0 shall store a bubble.
REQ-022 Forwarded rs1 (fwd_a): exmem_result if exmem_reg_write and exmem_rd_addr==registered rs1 addr and !=0; else memwb_result on same match against memwb; else registered rs1 data. fwd_b identical for rs2.
REQ-023 EX/MEM match shall take priority over MEM/WB; register x0 never forwarded.
REQ-024 operand_a = a_sel ? pc : fwd_a; operand_b = b_sel ? imm : fwd_b; ex_store_data = fwd_b regardless of b_sel.
REQ-025 Forwarding and operand muxes combinational from registered state and forwarding inputs (zero added latency).
REQ-026 load_use_stall = ex_valid & ex_mem_read & ex_rd_addr!=0 & (ex_rd_addr==id_rs1_addr | ex_rd_addr==id_rs2_addr) & id_valid; combinational.
REQ-027 Latency: ID inputs visible at outputs one cycle after capture edge.
REQ-028 stall_in and load_use_stall together: hold wins; no bubble inserted.
REQ-029 flush and load_use_stall together: bubble; load_use_stall deasserts next cycle.

Reset
REQ-030 At rst edge: register = bubble, pc=0, imm=0, data=0; outputs after reset: alu_op=ALU_NOP, ex_valid=0, ex_reg_write=0, ex_mem_read=0, ex_rd_addr=0, load_use_stall=0, operand_a=0, operand_b=0, ex_store_data=0 (no forwarding active).
REQ-031 rst mid-stall or mid-flush overrides both; in-flight instruction discarded.

Verification
REQ-032 ADD x3,x1,x2, rs1_data=5, rs2_data=10, no forwarding -> next cycle operand_a=5, operand_b=10, alu_op=ALU_ADD, ex_valid=1.
REQ-033 rs1=x4, exmem (rd=4, we=1, 0x11) and memwb (rd=4, we=1, 0x22) -> operand_a=0x11; exmem_reg_write=0 -> 0x22.
REQ-034 rs1=x0, exmem rd=0 we=1 result 0xDEAD, rs1_data=0 -> operand_a=0.
REQ-035 EX holds load to x5, ID rs2=x5 -> load_use_stall=1; next cycle alu_op=ALU_NOP, ex_valid=0, load_use_stall=0.
REQ-036 stall_in=1 for 3 cycles with ID inputs changing -> outputs unchanged; flush=1 -> next cycle ex_valid=0, alu_op=ALU_NOP.
REQ-037 a_sel=1, pc=0x100, b_sel=1, imm=0xFFFFFFFC, rs2 forwarded 0x77 -> operand_a=0x100, operand_b=0xFFFFFFFC, ex_store_data=0x77.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline stage: captures the decoded instruction, forwards results
// from EX/MEM and MEM/WB into the ALU operands and detects load-use hazards.

package control_types_pkg;
  typedef enum logic [3:0] {
    ALU_NOP  = 4'd0,
    ALU_ADD  = 4'd1,
    ALU_SUB  = 4'd2,
    ALU_AND  = 4'd3,
    ALU_OR   = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SLL  = 4'd6,
    ALU_SRL  = 4'd7,
    ALU_SRA  = 4'd8,
    ALU_SLT  = 4'd9,
    ALU_SLTU = 4'd10,
    ALU_LUI  = 4'd11
  } alu_op_t;
endpackage

module id_ex_stage
  import control_types_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_in,
  input  logic        flush,
  input  logic        id_valid,
  input  logic [31:0] id_pc,
  input  logic [31:0] id_imm,
  input  logic [31:0] id_rs1_data,
  input  logic [31:0] id_rs2_data,
  input  logic [4:0]  id_rs1_addr,
  input  logic [4:0]  id_rs2_addr,
  input  logic [4:0]  id_rd_addr,
  input  alu_op_t     id_alu_op,
  input  logic        id_a_sel,
  input  logic        id_b_sel,
  input  logic        id_reg_write,
  input  logic        id_mem_read,
  input  logic        exmem_reg_write,
  input  logic [4:0]  exmem_rd_addr,
  input  logic [31:0] exmem_result,
  input  logic        memwb_reg_write,
  input  logic [4:0]  memwb_rd_addr,
  input  logic [31:0] memwb_result,
  output logic [31:0] operand_a,
  output logic [31:0] operand_b,
  output alu_op_t     alu_op,
  output logic        ex_valid,
  output logic        ex_reg_write,
  output logic        ex_mem_read,
  output logic [4:0]  ex_rd_addr,
  output logic [31:0] ex_store_data,
  output logic        load_use_stall
);

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  // Registered control fields
  logic              vld_p0;
  logic [REG_W-1:0]  rs1_addr_p0;
  logic [REG_W-1:0]  rs2_addr_p0;
  logic [REG_W-1:0]  rd_addr_p0;
  alu_op_t           alu_op_p0;
  logic              a_sel_p0;
  logic              b_sel_p0;
  logic              reg_write_p0;
  logic              mem_read_p0;

  // Registered data fields
  logic [DATA_W-1:0] pc_p0;
  logic [DATA_W-1:0] imm_p0;
  logic [DATA_W-1:0] rs1_data_p0;
  logic [DATA_W-1:0] rs2_data_p0;

  logic              capture_en;
  logic [DATA_W-1:0] fwd_a;
  logic [DATA_W-1:0] fwd_b;

  // Select the freshest value of a source register. EX/MEM is younger than
  // MEM/WB so it wins; x0 is hard-wired to zero and is never forwarded.
  function automatic logic [DATA_W-1:0] forward_sel(
    input logic [REG_W-1:0]  src_addr,
    input logic [DATA_W-1:0] reg_data,
    input logic              em_we,
    input logic [REG_W-1:0]  em_rd,
    input logic [DATA_W-1:0] em_res,
    input logic              mw_we,
    input logic [REG_W-1:0]  mw_rd,
    input logic [DATA_W-1:0] mw_res
  );
    logic [DATA_W-1:0] sel;
    sel = reg_data;
    if (src_addr != '0) begin
      if (em_we && (em_rd == src_addr))
        sel = em_res;
      else if (mw_we && (mw_rd == src_addr))
        sel = mw_res;
    end
    return sel;
  endfunction

  // Load-use hazard: the instruction in EX is a load whose destination is
  // read by the instruction currently in ID.
  assign load_use_stall = vld_p0 & mem_read_p0 & (rd_addr_p0 != '0) &
                          ((rd_addr_p0 == id_rs1_addr) | (rd_addr_p0 == id_rs2_addr)) &
                          id_valid;

  // A real instruction is taken only when nothing of higher priority applies;
  // on bubbles the data fields simply keep their old (don't-care) contents.
  assign capture_en = ~flush & ~stall_in & ~load_use_stall & id_valid;

  // Control fields: rst > flush > hold > load-use bubble > capture
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      vld_p0       <= 1'b0;
      rs1_addr_p0  <= '0;
      rs2_addr_p0  <= '0;
      rd_addr_p0   <= '0;
      alu_op_p0    <= ALU_NOP;
      a_sel_p0     <= 1'b0;
      b_sel_p0     <= 1'b0;
      reg_write_p0 <= 1'b0;
      mem_read_p0  <= 1'b0;
    end else if (!stall_in) begin
      if (capture_en) begin
        vld_p0       <= 1'b1;
        rs1_addr_p0  <= id_rs1_addr;
        rs2_addr_p0  <= id_rs2_addr;
        rd_addr_p0   <= id_rd_addr;
        alu_op_p0    <= id_alu_op;
        a_sel_p0     <= id_a_sel;
        b_sel_p0     <= id_b_sel;
        reg_write_p0 <= id_reg_write;
        mem_read_p0  <= id_mem_read;
      end else begin
        vld_p0       <= 1'b0;
        rs1_addr_p0  <= '0;
        rs2_addr_p0  <= '0;
        rd_addr_p0   <= '0;
        alu_op_p0    <= ALU_NOP;
        a_sel_p0     <= 1'b0;
        b_sel_p0     <= 1'b0;
        reg_write_p0 <= 1'b0;
        mem_read_p0  <= 1'b0;
      end
    end
  end

  // Data fields: cleared on reset so operands read zero, loaded on capture
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_p0       <= '0;
      imm_p0      <= '0;
      rs1_data_p0 <= '0;
      rs2_data_p0 <= '0;
    end else if (capture_en) begin
      pc_p0       <= id_pc;
      imm_p0      <= id_imm;
      rs1_data_p0 <= id_rs1_data;
      rs2_data_p0 <= id_rs2_data;
    end
  end

  // ---- EX side: combinational forwarding and operand selection ----

  // Forwarding and operand muxes from registered state
  always_comb begin
    fwd_a = forward_sel(rs1_addr_p0, rs1_data_p0,
                        exmem_reg_write, exmem_rd_addr, exmem_result,
                        memwb_reg_write, memwb_rd_addr, memwb_result);
    fwd_b = forward_sel(rs2_addr_p0, rs2_data_p0,
                        exmem_reg_write, exmem_rd_addr, exmem_result,
                        memwb_reg_write, memwb_rd_addr, memwb_result);
    operand_a     = a_sel_p0 ? pc_p0  : fwd_a;
    operand_b     = b_sel_p0 ? imm_p0 : fwd_b;
    ex_store_data = fwd_b;
  end

  assign alu_op       = alu_op_p0;
  assign ex_valid     = vld_p0;
  assign ex_reg_write = reg_write_p0;
  assign ex_mem_read  = mem_read_p0;
  assign ex_rd_addr   = rd_addr_p0;

endmodule
